// File: rtl/pc_branch_unit.sv
// PC register and next-PC generator (jr > jump > branch > pc+4); optional RAS checker under PC_BRANCH_RAS_EN.
// One-cycle PC update latency; en=0 stalls pc, instr_count, fault and the RAS.
module pc_branch_unit #(
   parameter int               WIDTH     = 32,
   parameter int               IMM_W     = 16,
   parameter logic [WIDTH-1:0] RESET_PC  = '0,
   parameter int               RAS_DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             branch,
   input  logic [IMM_W-1:0] imm,
   input  logic             jump,
   input  logic             link,
   input  logic [25:0]      jump_index,
   input  logic             jr,
   input  logic [WIDTH-1:0] jr_target,
   output logic [WIDTH-1:0] pc,
   output logic [WIDTH-1:0] pc_plus4,
   output logic [WIDTH-1:0] branch_target,
   output logic [WIDTH-1:0] instr_count,
   output logic             fault,
   output logic             ras_empty,
   output logic             ras_mispredict
);

   logic [WIDTH-1:0] imm_ext;
   logic [WIDTH-1:0] jump_target;
   logic [WIDTH-1:0] next_target;
   logic             misaligned;

   assign pc_plus4      = pc + WIDTH'(4);
   assign imm_ext       = {{(WIDTH-IMM_W){imm[IMM_W-1]}}, imm};
   assign branch_target = pc_plus4 + (imm_ext << 2);
   assign jump_target   = {pc_plus4[WIDTH-1:28], jump_index, 2'b00};

   always_comb begin
      next_target = pc_plus4;
      if (jr)
         next_target = jr_target;
      else if (jump)
         next_target = jump_target;
      else if (branch)
         next_target = branch_target;
   end

   // Only jr_target can carry low bits; the PC is forced word-aligned anyway.
   assign misaligned = (next_target[1:0] != 2'b00);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc          <= RESET_PC;
         instr_count <= '0;
         fault       <= 1'b0;
      end else if (en) begin
         pc          <= {next_target[WIDTH-1:2], 2'b00};
         instr_count <= instr_count + WIDTH'(1);
         fault       <= fault | misaligned;
      end
   end

`ifdef PC_BRANCH_RAS_EN
   localparam int PTR_W = $clog2(RAS_DEPTH);

   logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
   logic [PTR_W-1:0] ras_wr_ptr;
   logic [PTR_W-1:0] ras_top_ptr;
   logic [PTR_W:0]   ras_cnt;
   logic             ras_push;
   logic             ras_pop;

   assign ras_push    = en & jump & link & ~jr;
   assign ras_pop     = en & jr & ~ras_empty;
   assign ras_top_ptr = ras_wr_ptr - PTR_W'(1);
   assign ras_empty   = (ras_cnt == '0);
   assign ras_mispredict = jr & ~ras_empty & (ras_mem[ras_top_ptr] != jr_target);

   // When full, the write slot is the oldest entry, so a push overwrites it.
   always_ff @(posedge clk) begin
      if (ras_push)
         ras_mem[ras_wr_ptr] <= pc_plus4;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ras_wr_ptr <= '0;
         ras_cnt    <= '0;
      end else if (ras_push) begin
         ras_wr_ptr <= ras_wr_ptr + PTR_W'(1);
         if (ras_cnt != (PTR_W+1)'(RAS_DEPTH))
            ras_cnt <= ras_cnt + (PTR_W+1)'(1);
      end else if (ras_pop) begin
         ras_wr_ptr <= ras_top_ptr;
         ras_cnt    <= ras_cnt - (PTR_W+1)'(1);
      end
   end
`else
   logic ras_unused;
   assign ras_unused     = link ^ (RAS_DEPTH > 0);
   assign ras_empty      = 1'b1;
   assign ras_mispredict = 1'b0;
`endif

endmodule

// File: doc/pc_branch_unit.md
# pc_branch_unit

Parametrised program-counter and next-PC generator for the MIPS single-cycle core. It holds the PC register and forms PC+4, the branch target (PC+4 plus the sign-extended, word-shifted immediate) and the jump target. It selects the next PC by priority (jr, jump, branch, sequential) and honours a stall enable. It also keeps a retired-instruction counter and a sticky misalignment fault, and can optionally include a return-address stack that checks `jr` targets.

## Interface
Parameters:
- `WIDTH`, 32, PC/datapath width; legal range 32..64.
- `IMM_W`, 16, branch immediate width; must be less than `WIDTH`.
- `RESET_PC`, 0, PC value after reset; must be word-aligned.
- `RAS_DEPTH`, 4, return-address stack entries (power of two, 2..16); used only with `RAS_EN`.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `en`  in  1  1 = advance PC this cycle; 0 = stall (hold all state).
- `branch`  in  1  branch taken (condition already resolved).
- `imm`  in  IMM_W  branch offset in words, signed.
- `jump`  in  1  j/jal.
- `link`  in  1  qualifies `jump` as jal (RAS push).
- `jump_index`  in  26  instr[25:0].
- `jr`  in  1  jump register.
- `jr_target`  in  WIDTH  register-file value for jr.
- `pc`  out  WIDTH  current PC (registered).
- `pc_plus4`  out  WIDTH  pc + 4 (combinational).
- `branch_target`  out  WIDTH  pc_plus4 + (sext(imm) << 2) (combinational).
- `instr_count`  out  WIDTH  retired-instruction count (registered).
- `fault`  out  1  sticky misaligned-target flag (registered).
- `ras_empty`  out  1  RAS holds no entries.
- `ras_mispredict`  out  1  combinational; jr with non-empty RAS whose top differs from `jr_target`.

## Operation
- Next-PC selection when `en`=1, highest priority first:
  - `jr` selects `jr_target`.
  - `jump` selects {pc_plus4[WIDTH-1:28], jump_index, 2'b00}.
  - `branch` selects `branch_target`.
  - Otherwise selects `pc_plus4`.
- Simultaneous flags: only the highest-priority one acts. For example, `jr` with `jump`+`link` means no push.
- All adds are modulo 2^WIDTH. Wrap-around is silent, and PC = 2^WIDTH−4 advances to 0.
- Sign extension replicates `imm[IMM_W-1]`.
- Alignment: if the selected target has bits [1:0] ≠ 0 (only reachable via `jr_target`):
  - PC loads the target with bits [1:0] cleared.
  - `fault` sets and stays set until `reset`.
- `instr_count` increments by 1 on every `en`=1 edge and wraps to 0.
- `en`=0: `pc`, `instr_count`, `fault` and RAS are unchanged. Combinational outputs still track `pc`.
- Reset values:
  - `pc`=`RESET_PC`, `instr_count`=0, `fault`=0.
  - RAS empty, so `ras_empty`=1 and `ras_mispredict`=0.

## Timing
- One-cycle latency: the selection made in cycle n appears on `pc` after the rising edge ending cycle n.
- `pc_plus4`, `branch_target` and `ras_mispredict` are valid in the same cycle as `pc` and the inputs; there is no registered delay.
- `reset` asserted mid-operation forces the reset values immediately, without waiting for `clk`, and holds them while high.
- The first advance occurs on the first `clk` edge with `reset` low and `en` high.

## Configuration
- `PC_BRANCH_RAS_EN` defined: a `RAS_DEPTH`-entry circular return-address stack is built.
  - Push: `en` & `jump` & `link` & !`jr` pushes `pc_plus4`.
  - Full push: overwrites the oldest entry; occupancy saturates at `RAS_DEPTH`.
  - Pop: `en` & `jr` pops when non-empty. An empty pop is a no-op and `ras_mispredict`=0.
  - The architectural PC always takes `jr_target`; the RAS is a checker only.
- `PC_BRANCH_RAS_EN` undefined: no stack storage is built. `ras_empty` is tied to 1, `ras_mispredict` is tied to 0, and `link` is ignored.

## Test plan
- Reset/sequence: `RESET_PC`=0x00400000, release reset, `en`=1 for 3 cycles → `pc` = 0x00400004, 0x00400008, 0x0040000C; `instr_count` = 3.
- Branch: pc=0x00400010, `branch`=1, `imm`=0xFFFE → `branch_target`=0x0040000C, and `pc`=0x0040000C next cycle; `imm`=0x7FFF gives 0x00420010.
- Priority/stall:
  - `jr`=1, `jump`=1, `branch`=1, `jr_target`=0x1000 → `pc`=0x1000.
  - Then `en`=0 for 2 cycles → `pc` stays 0x1000 and `instr_count` is unchanged.
- Jump/wrap:
  - pc=0x8FFFFFF8, `jump`=1, `jump_index`=0x0000010 → `pc`=0x80000040.
  - pc=0xFFFFFFFC, no flags → `pc`=0x00000000.
- Fault: `jr_target`=0x00001003 → `pc`=0x00001000 and `fault`=1. It stays 1 through later cycles and clears only on `reset` (async, mid-cycle).
- RAS (with `PC_BRANCH_RAS_EN`, `RAS_DEPTH`=4):
  - Five jal pushes at pc 0x100, 0x200, 0x300, 0x400, 0x500 → four pops return 0x504, 0x404, 0x304, 0x204.
  - A fifth `jr` after that sees `ras_empty`=1 and `ras_mispredict`=0.
  - `jr` with top 0x504 and `jr_target`=0x508 → `ras_mispredict`=1 and `pc`=0x508.
